// File: rtl/snake_pkg.sv
// Shared constants and state encoding for the LED snake pattern path
// (pattern generator, run counter, display scan).
package snake_pkg;

  localparam int CNT_LENGTH = 20;
  localparam int LED_W      = 16;
  localparam int SNAKE_LEN  = 4;
  localparam int RUN_MAX    = 9;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/snake_prescaler.sv
// Clock prescaler: one-cycle tick every CLK_DIV enabled clk cycles; the
// count holds while en is low so a held-off tick fires as soon as en returns.
module snake_prescaler #(
  parameter int CLK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign tick = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/snake_ptn_gen.sv
// LED snake pattern-position generator: stepped up/down position counter with
// direction latched only at run boundaries, plus the 16-LED snake image decode.
module snake_ptn_gen #(
  parameter int CLK_DIV    = 5_000_000,
  parameter int CNT_LENGTH = snake_pkg::CNT_LENGTH,
  parameter int LED_W      = snake_pkg::LED_W,
  parameter int SNAKE_LEN  = snake_pkg::SNAKE_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          updn_in,
  input  logic                          pause,
  input  logic                          run_stop,
  output logic [$clog2(CNT_LENGTH)-1:0] ptn_cnt,
  output logic                          updn,
  output logic                          step,
  output logic                          run_end,
  output logic [LED_W-1:0]              led
);

  import snake_pkg::*;

  localparam int CNT_W = $clog2(CNT_LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LENGTH - 1);
  // Last position with a segment still on the board; later positions hold it
  // so the final frame of a run shows the tail on the end LED instead of going dark.
  localparam int POS_MAX = LED_W + SNAKE_LEN - 2;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] ptn_nxt;
  logic             updn_nxt;
  logic             updn_meta;
  logic             updn_s;
  logic             pre_en;

  function automatic logic [LED_W-1:0] snake_image(input logic [CNT_W-1:0] pos);
    logic [5:0]       p;
    logic [LED_W-1:0] img;
    p   = (6'(pos) > 6'(POS_MAX)) ? 6'(POS_MAX) : 6'(pos);
    img = '0;
    for (int i = 0; i < LED_W; i++) begin
      img[i] = (p >= 6'(i)) && (p < 6'(i + SNAKE_LEN));
    end
    return img;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      updn_meta <= 1'b1;
      updn_s    <= 1'b1;
    end else begin
      updn_meta <= updn_in;
      updn_s    <= updn_meta;
    end
  end

  assign pre_en = !pause && (state != STOP);

  snake_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .tick (step)
  );

  assign run_end = (updn && (ptn_cnt == CNT_LAST)) || (!updn && (ptn_cnt == '0));

  always_comb begin
    state_nxt = state;
    ptn_nxt   = ptn_cnt;
    updn_nxt  = updn;
    case (state)
      INIT: begin
        if (run_stop) begin
          state_nxt = STOP;
        end else if (step) begin
          updn_nxt  = updn_s;
          ptn_nxt   = updn_s ? '0 : CNT_LAST;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (run_stop) begin
          state_nxt = STOP;
        end else if (step) begin
          if (run_end) begin
            updn_nxt = updn_s;
            ptn_nxt  = updn_s ? '0 : CNT_LAST;
          end else begin
            ptn_nxt = updn ? ptn_cnt + CNT_W'(1) : ptn_cnt - CNT_W'(1);
          end
        end
      end
      STOP: begin
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      ptn_cnt <= '0;
      updn    <= 1'b1;
    end else begin
      state   <= state_nxt;
      ptn_cnt <= ptn_nxt;
      updn    <= updn_nxt;
    end
  end

  always_comb begin
    led = '0;
    case (state)
      RUN:     led = snake_image(ptn_cnt);
      STOP:    led = '1;
      default: led = '0;
    endcase
  end

endmodule

// File: doc/snake_ptn_gen.md
# snake_ptn_gen

Pattern-position generator for the LED snake: divides the board clock into a step strobe and advances a 0..CNT_LENGTH-1 pattern counter up or down. It decodes that position into a 16-LED snake image. It sits directly upstream of the run counter, which consumes `ptn_cnt` and the latched direction `updn` and returns `run_stop` once nine runs are complete. Direction is latched only at run boundaries, so one run is never split between directions.

## Interface
- `CLK_DIV`, 5_000_000: clk cycles per step (10 steps/s at 50 MHz); minimum 2.
- `CNT_LENGTH`, 20: pattern positions per run; must equal `LED_W + SNAKE_LEN`.
- `LED_W`, 16: LED count.
- `SNAKE_LEN`, 4: lit segments (head plus body).
- `clk` in 1: board clock.
- `rst` in 1: reset, asynchronous, active-high.
- `updn_in` in 1: direction switch, asynchronous (1 = up, 0 = down).
- `pause` in 1: synchronous; freezes the prescaler and the pattern.
- `run_stop` in 1: from the run counter; 1 = all runs done.
- `ptn_cnt` out 5: current pattern position.
- `updn` out 1: latched direction; drives the run counter's `updn`.
- `step` out 1: one-cycle strobe; `ptn_cnt` changes only on a step edge.
- `run_end` out 1: 1 while `ptn_cnt` is at the terminal value for `updn`.
- `led` out LED_W: snake image.

## Operation
- `updn_in` passes through a 2-FF synchronizer to give `updn_s`.
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps. `step` = (`div_cnt`==CLK_DIV-1) && !`pause` && state!=STOP. The prescaler holds while `pause`=1 or in STOP.
- States:
  - INIT (reset state): on `step`, latch `updn`<=`updn_s`; `ptn_cnt`<=0 if up, else CNT_LENGTH-1; go to RUN.
  - RUN: on `step`, one of two cases.
    - Not at terminal: `ptn_cnt` +1 (up) or -1 (down).
    - At terminal (up: CNT_LENGTH-1; down: 0): latch `updn`<=`updn_s`; reload 0 (new up) or CNT_LENGTH-1 (new down).
  - STOP: entered on any clk where `run_stop`=1 in INIT or RUN. Absorbing until `rst`. `ptn_cnt` and `updn` frozen; `step` held 0.
- `run_stop` and `step` in the same cycle: STOP wins, no advance.
- `run_end` = (`updn` && `ptn_cnt`==CNT_LENGTH-1) || (!`updn` && `ptn_cnt`==0).
- LED decode, combinational from registered `ptn_cnt`:
  - `led[i]`=1 iff i <= `ptn_cnt` < i+SNAKE_LEN.
  - Use 6-bit unsigned compares; no subtraction underflow.
  - Position 0 lights `led[0]` only. Position 19 lights `led[15]` only. Positions 3..15 light four LEDs.
- In STOP, `led` = all ones (done indication).
- In INIT, `led` = 0.
- Reset values: `ptn_cnt`=0, `updn`=1, `step`=0, `led`=0, `div_cnt`=0, state INIT, synchronizer = 1.
- `rst` mid-run: all state returns to the reset values asynchronously. The first `step` after release lands CLK_DIV cycles later.

## Timing
- `step` asserts exactly once per CLK_DIV unpaused cycles.
- `ptn_cnt`, `updn` and `led` update on the edge where `step`=1 and are valid from the next cycle.
- Direction latency: switch edge, then 2 clk of synchronizer, then it takes effect at the next run boundary only. A toggle mid-run has no effect until the terminal step.
- `run_stop` to STOP: 1 clk. `led` is all ones from the following cycle.
- A pause asserted in the cycle where `div_cnt`=CLK_DIV-1 suppresses that step. The step fires on the first unpaused cycle after release.
- Downstream consumption: the run counter must sample `ptn_cnt` only on `step` cycles. Each terminal position is then counted once per run.

## Structure
- Shared package `snake_pkg` holds:
  - CNT_LENGTH=20, LED_W=16, SNAKE_LEN=4;
  - the state encoding (INIT=2'd0, RUN=2'd1, STOP=2'd2);
  - RUN_MAX=9.
- Sub-module `snake_prescaler` (parameter CLK_DIV; ports clk, rst, en, tick) is shared with the display scan logic.
- The synchronizer, FSM and LED decode live in this module.

## Test plan
All scenarios use CLK_DIV=4.
- Reset release with `updn_in`=1:
  - first `step` at cycle 4, `ptn_cnt`=0, `led`=16'h0001;
  - `ptn_cnt`=3 gives `led`=16'h000F;
  - 19 gives 16'h8000, with `run_end`=1;
  - the next step gives 0.
- Start with `updn_in`=0: first step loads 19 (`led`=16'h8000), then counts down to 0 with `run_end`=1, then reloads 19.
- Toggle `updn_in` 1→0 at `ptn_cnt`=7: counting continues up to 19; the next step loads 19 with `updn`=0.
- Assert `pause` for 10 cycles at `ptn_cnt`=5: no `step`, `ptn_cnt` stays 5; the next step is 4 unpaused cycles after release.
- Pulse `run_stop` in the same cycle as `step` at `ptn_cnt`=12: `ptn_cnt` stays 12, `led`=16'hFFFF, no further steps over 40 cycles.
- Assert `rst` at `ptn_cnt`=9 while `updn`=0: all outputs go to the reset values immediately; normal restart follows as in the first scenario.
